// File: rtl/mux_stream_nto1.sv
// N-input registered stream multiplexer: explicit select (mode 0) or round-robin (mode 1).
// Define MUX_LOCK_EN to add in_last and hold a round-robin grant for a whole packet.
module mux_stream_nto1 #(
   parameter  int WIDTH = 32,
   parameter  int N_IN  = 4,
   localparam int SEL_W = $clog2(N_IN)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [N_IN-1:0]       in_valid,
`ifdef MUX_LOCK_EN
   input  logic [N_IN-1:0]       in_last,
`endif
   output logic [N_IN-1:0]       in_ready,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  mode,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SEL_W-1:0]      out_chan
);

   logic [N_IN-1:0][WIDTH-1:0] din;
   logic [SEL_W-1:0]           rr_ptr, rr_g, idx, g, lock_ch;
   logic                       rr_hit, sel_hit, grant, load_en, xfer, locked;

   for (genvar i = 0; i < N_IN; i++) begin : g_lane
      assign din[i]      = in_data[i*WIDTH +: WIDTH];
      assign in_ready[i] = xfer && (g == SEL_W'(i));
   end

   assign load_en = !out_valid || out_ready;
   // rst_n gate keeps every in_ready low while reset is asserted
   assign xfer    = rst_n && load_en && grant;

   // first requester after rr_ptr, wrapping at N_IN
   always_comb begin
      rr_hit = 1'b0;
      rr_g   = '0;
      idx    = '0;
      for (int k = 1; k <= N_IN; k++) begin
         idx = SEL_W'((int'(rr_ptr) + k) % N_IN);
         if (!rr_hit && in_valid[idx]) begin
            rr_hit = 1'b1;
            rr_g   = idx;
         end
      end
   end

   // out-of-range sel never matches, so it simply grants nothing
   always_comb begin
      sel_hit = 1'b0;
      for (int i = 0; i < N_IN; i++)
         if (sel == SEL_W'(i)) sel_hit = in_valid[i];
   end

`ifdef MUX_LOCK_EN
   typedef enum logic {S_IDLE, S_LOCKED} lock_st_t;
   lock_st_t st, st_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= S_IDLE;
         lock_ch <= '0;
      end else begin
         st <= st_nxt;
         if (st == S_IDLE && st_nxt == S_LOCKED) lock_ch <= g;
      end
   end

   always_comb begin
      st_nxt = st;
      case (st)
         S_IDLE:   if (mode && xfer && !in_last[g]) st_nxt = S_LOCKED;
         S_LOCKED: if (!mode) st_nxt = S_IDLE;
                   else if (xfer && in_last[lock_ch]) st_nxt = S_IDLE;
         default:  st_nxt = S_IDLE;
      endcase
   end

   always_comb locked = (st == S_LOCKED) && mode;
`else
   assign locked  = 1'b0;
   assign lock_ch = '0;
`endif

   always_comb begin
      if (!mode) begin
         grant = sel_hit;
         g     = sel;
      end else if (locked) begin
         grant = in_valid[lock_ch];
         g     = lock_ch;
      end else begin
         grant = rr_hit;
         g     = rr_g;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         rr_ptr    <= SEL_W'(N_IN - 1);
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= din[g];
         out_chan  <= g;
         if (mode) rr_ptr <= g;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_stream_nto1.sv
// Bench for mux_stream_nto1: vector table, corner-case sequences, randomized run vs a reference model.
module tb_mux_stream_nto1;
   localparam int W = 32, N = 4, SW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid, in_ready;
   logic [SW-1:0]  sel, out_chan;
   logic           mode, out_valid, out_ready;
   logic [W-1:0]   out_data;
`ifdef MUX_LOCK_EN
   logic [N-1:0]   in_last;
   logic [2:0]     d3_last;
`endif

   logic [3*W-1:0] d3_data;
   logic [2:0]     d3_valid, d3_ready;
   logic [1:0]     d3_sel, d3_chan;
   logic           d3_mode, d3_ovalid, d3_ordy;
   logic [W-1:0]   d3_odata;

   mux_stream_nto1 #(.WIDTH(W), .N_IN(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
`ifdef MUX_LOCK_EN
      .in_last(in_last),
`endif
      .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan));

   mux_stream_nto1 #(.WIDTH(W), .N_IN(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_data(d3_data), .in_valid(d3_valid),
`ifdef MUX_LOCK_EN
      .in_last(d3_last),
`endif
      .in_ready(d3_ready), .sel(d3_sel), .mode(d3_mode), .out_data(d3_odata),
      .out_valid(d3_ovalid), .out_ready(d3_ordy), .out_chan(d3_chan));

   int total = 0, bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [W-1:0] td(input int c);
      return 32'hCAFE0000 + W'(c);
   endfunction

   task automatic load_table_data();
      for (int i = 0; i < N; i++) in_data[i*W +: W] = td(i);
   endtask

   // call at a negedge; checks in_ready now and the registered outputs after the edge
   task automatic step(input string nm, input bit m, input logic [1:0] s, input logic [3:0] iv,
                       input bit ordy, input logic [3:0] er, input bit ev, input logic [1:0] ec);
      mode = m; sel = s; in_valid = iv; out_ready = ordy;
      #1 chk({nm, " in_ready"}, 64'(in_ready), 64'(er));
      @(negedge clk);
      chk({nm, " out_valid"}, 64'(out_valid), 64'(ev));
      chk({nm, " out_chan"}, 64'(out_chan), 64'(ec));
      chk({nm, " out_data"}, 64'(out_data), 64'(td(int'(ec))));
   endtask

   task automatic do_reset();
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
   endtask

   typedef struct {
      bit m; logic [1:0] s; logic [3:0] iv; bit ordy;
      logic [3:0] er; bit ev; logic [1:0] ec;
   } vec_t;
   vec_t tbl[12];

   // reference model state: output register contents and round-robin pointer
   bit             mv;
   logic [W-1:0]   md;
   int             mc, mptr;

   initial begin
      rst_n = 1'b0; mode = 1'b1; sel = '0; in_valid = '1; out_ready = 1'b1;
      load_table_data();
      d3_data = {32'hD3000002, 32'hD3000001, 32'hD3000000};
      d3_valid = '0; d3_sel = '0; d3_mode = 1'b0; d3_ordy = 1'b1;
`ifdef MUX_LOCK_EN
      in_last = '1; d3_last = '1;
`endif
      tbl[0]  = '{0, 2, 4'b0100, 1, 4'b0100, 1, 2};
      tbl[1]  = '{1, 0, 4'b1111, 1, 4'b0001, 1, 0};
      tbl[2]  = '{1, 0, 4'b1111, 1, 4'b0010, 1, 1};
      tbl[3]  = '{1, 0, 4'b1111, 1, 4'b0100, 1, 2};
      tbl[4]  = '{1, 0, 4'b1111, 1, 4'b1000, 1, 3};
      tbl[5]  = '{1, 0, 4'b1111, 1, 4'b0001, 1, 0};
      tbl[6]  = '{1, 0, 4'b1111, 0, 4'b0000, 1, 0};
      tbl[7]  = '{1, 0, 4'b1111, 0, 4'b0000, 1, 0};
      tbl[8]  = '{0, 1, 4'b0000, 1, 4'b0000, 0, 0};
      tbl[9]  = '{0, 3, 4'b1000, 0, 4'b1000, 1, 3};
      tbl[10] = '{1, 0, 4'b0110, 1, 4'b0010, 1, 1};
      tbl[11] = '{1, 0, 4'b0101, 1, 4'b0100, 1, 2};

      // reset state, with requests pending to prove in_ready is gated
      @(negedge clk); #1;
      chk("rst out_valid", 64'(out_valid), 64'(0));
      chk("rst out_data", 64'(out_data), 64'(0));
      chk("rst out_chan", 64'(out_chan), 64'(0));
      chk("rst in_ready", 64'(in_ready), 64'(0));
      @(negedge clk) rst_n = 1'b1;
      mode = 1'b0; in_valid = '0;

      foreach (tbl[i])
         step($sformatf("vec%0d", i), tbl[i].m, tbl[i].s, tbl[i].iv, tbl[i].ordy,
              tbl[i].er, tbl[i].ev, tbl[i].ec);

      // backpressure: held beat stays stable, then pop and load in one cycle
      mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_data[W-1:0] = $urandom;
         #1 chk($sformatf("stall%0d in_ready", k), 64'(in_ready), 64'(0));
         @(negedge clk);
         chk($sformatf("stall%0d out_valid", k), 64'(out_valid), 64'(1));
         chk($sformatf("stall%0d out_chan", k), 64'(out_chan), 64'(2));
         chk($sformatf("stall%0d out_data", k), 64'(out_data), 64'(td(2)));
      end
      out_ready = 1'b1;
      #1 chk("release in_ready", 64'(in_ready), 64'(4'b0001));
      @(negedge clk);
      chk("release out_chan", 64'(out_chan), 64'(0));
      chk("release out_data", 64'(out_data), 64'(in_data[W-1:0]));
      chk("release out_valid", 64'(out_valid), 64'(1));
      load_table_data();

      // out-of-range select on a 3-input instance
      d3_mode = 1'b0; d3_valid = 3'b111; d3_ordy = 1'b1; d3_sel = 2'd0;
      #1 chk("oor pre in_ready", 64'(d3_ready), 64'(3'b001));
      @(negedge clk);
      chk("oor pre out_valid", 64'(d3_ovalid), 64'(1));
      chk("oor pre out_data", 64'(d3_odata), 64'(32'hD3000000));
      d3_sel = 2'd3;
      for (int k = 0; k < 2; k++) begin
         #1 chk($sformatf("oor%0d in_ready", k), 64'(d3_ready), 64'(0));
         @(negedge clk);
         chk($sformatf("oor%0d out_valid", k), 64'(d3_ovalid), 64'(0));
         chk($sformatf("oor%0d out_chan", k), 64'(d3_chan), 64'(0));
      end
      d3_valid = '0;

      // asynchronous reset in the middle of a stream
      step("pre_rst", 1, 0, 4'b1111, 1, 4'b1000, 1, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("async out_valid", 64'(out_valid), 64'(0));
      chk("async out_data", 64'(out_data), 64'(0));
      chk("async in_ready", 64'(in_ready), 64'(0));
      @(negedge clk) rst_n = 1'b1;
      step("post_rst", 1, 0, 4'b1111, 1, 4'b0001, 1, 0);

      // randomized run against the reference model
      out_ready = 1'b0; in_valid = '0;
      do_reset();
      mv = 1'b0; md = '0; mc = 0; mptr = N - 1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         bit hit, ld;
         int gi;
         chk("rnd out_valid", 64'(out_valid), 64'(mv));
         chk("rnd out_chan", 64'(out_chan), 64'(mc));
         chk("rnd out_data", 64'(out_data), 64'(md));
         for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
         in_valid  = N'($urandom);
         mode      = 1'($urandom);
         sel       = SW'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         hit = 1'b0; gi = 0;
         if (!mode) begin
            hit = in_valid[sel]; gi = int'(sel);
         end else begin
            for (int k = 1; k <= N; k++)
               if (!hit && in_valid[(mptr + k) % N]) begin hit = 1'b1; gi = (mptr + k) % N; end
         end
         ld = !mv || out_ready;
         #1 chk("rnd in_ready", 64'(in_ready), (ld && hit) ? (64'd1 << gi) : 64'd0);
         if (ld && hit) begin
            mv = 1'b1; md = in_data[gi*W +: W]; mc = gi;
            if (mode) mptr = gi;
         end else if (out_ready) mv = 1'b0;
         @(negedge clk);
      end

`ifdef MUX_LOCK_EN
      // packet lock: ch1 keeps the grant for 3 beats while ch0/ch2 also request
      load_table_data();
      out_ready = 1'b0; in_valid = '0;
      do_reset();
      in_last = 4'b1111;
      step("lk0", 1, 0, 4'b0001, 1, 4'b0001, 1, 0);
      in_last = 4'b0101;
      step("lk1", 1, 0, 4'b0111, 1, 4'b0010, 1, 1);
      step("lk_gap", 1, 0, 4'b0101, 1, 4'b0000, 0, 1);
      step("lk2", 1, 0, 4'b0111, 1, 4'b0010, 1, 1);
      in_last = 4'b0111;
      step("lk3", 1, 0, 4'b0111, 1, 4'b0010, 1, 1);
      step("lk_next", 1, 0, 4'b0111, 1, 4'b0100, 1, 2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
